lsu_mem_port: RTL and testbench

Load/store initiator for the byte-addressed data memory in the MEM stage. Accepts one load/store request at a time from the pipeline over a valid/ready handshake and drives the memory port (address, store data, access size, unsigned flag, write enable). Aligned accesses complete in one memory cycle. Misaligned halfword/word accesses are split into sequential byte accesses, with load bytes assembled and extended locally. Returns a single-cycle response pulse carrying load data.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_extend.sv | 17 +
 rtl/lsu_mem_port.sv | 106 ++++++++++
 tb/tb_lsu_mem_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and split predicate for the LSU memory port.
package lsu_pkg;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  // Half on an odd address, or word (size 2 or 3) off a word boundary, goes out byte by byte.
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] lo);
    return (size == SIZE_H && lo[0]) || (size[1] && lo != 2'd0);
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of assembled load data by access size and unsigned flag.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              un,
  output logic [DATA_W-1:0] ext
);
  always_comb begin
    ext = size[1] ? data :
          size == SIZE_H ? {{(DATA_W-16){~un & data[15]}}, data[15:0]} :
                           {{(DATA_W-8){~un & data[7]}}, data[7:0]};
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: MEM-stage load/store initiator; aligned accesses go out in one cycle,
// misaligned half/word accesses are split into byte accesses and reassembled locally.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic              req_write,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_split,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        mem_acc_size,
  output logic              mem_un,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, result, asm_data, asm_next, ext;
  logic [1:0]        size, k, last_k;
  logic              un, write, split, res_split;
  logic              accept, in_acc, done;
  logic [4:0]        sh;
  logic [7:0]        byte_k;

  always_comb begin
    req_ready = reset_n && (state == IDLE || state == RESP);
    accept    = req_valid && req_ready;
    in_acc    = state == ACCESS;
    last_k    = size == SIZE_H ? 2'd1 : 2'd3;
    done      = !split || k == last_k;
    sh        = {k, 3'b000};
    byte_k    = wdata[sh +: 8];
    state_n   = accept ? ACCESS : in_acc ? (done ? RESP : ACCESS) : IDLE;
  end

  // Byte k of the load lands in lane k of the assembly word (little-endian).
  always_comb begin
    asm_next = (asm_data & ~(DATA_W'(8'hFF) << sh)) | (DATA_W'(mem_rdata[7:0]) << sh);
  end

  lsu_extend #(.DATA_W(DATA_W)) u_ext (
    .data (asm_next),
    .size (size),
    .un   (un),
    .ext  (ext)
  );

  always_comb begin
    mem_addr     = in_acc ? (split ? addr + ADDR_W'(k) : addr) : '0;
    mem_data     = in_acc ? (split ? {{(DATA_W-8){1'b0}}, byte_k} : wdata) : '0;
    mem_acc_size = in_acc ? (split ? SIZE_B : size) : SIZE_B;
    mem_un       = in_acc && (split || un);
    mem_wen      = in_acc && write;
    resp_valid   = state == RESP;
    resp_rdata   = resp_valid ? result : '0;
    resp_split   = resp_valid && res_split;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      wdata     <= '0;
      size      <= SIZE_B;
      un        <= 1'b0;
      write     <= 1'b0;
      split     <= 1'b0;
      k         <= 2'd0;
      asm_data  <= '0;
      result    <= '0;
      res_split <= 1'b0;
    end else if (accept) begin
      addr     <= req_addr;
      wdata    <= req_wdata;
      size     <= req_size;
      un       <= req_unsigned;
      write    <= req_write;
      split    <= is_split(req_size, req_addr[1:0]);
      k        <= 2'd0;
      asm_data <= '0;
    end else if (in_acc) begin
      k        <= k + 2'd1;
      asm_data <= asm_next;
      if (done) begin
        result    <= write ? '0 : split ? ext : mem_rdata;
        res_split <= split;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: table-driven requests against a byte memory model, scoreboarded responses,
// per-request memory access trace checks, back-to-back and reset-abort sequences.
module tb_lsu_mem_port;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned, req_write;
  logic        resp_valid, resp_split;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [1:0]  mem_acc_size;
  logic        mem_un, mem_wen;

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_write(req_write), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_split(resp_split), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_acc_size(mem_acc_size), .mem_un(mem_un), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // 4 KiB memory image; addresses alias modulo 4096, so 0xFFFFFFFF and 0x0 are neighbours.
  logic [7:0]  mem [0:4095] = '{default: 8'h00};
  logic [11:0] ma;
  logic [31:0] mw;
  assign ma = mem_addr[11:0];
  always_comb begin
    mw = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
    mem_rdata = mem_acc_size[1] ? mw :
                mem_acc_size == 2'd1 ? {{16{~mem_un & mw[15]}}, mw[15:0]} :
                                       {{24{~mem_un & mw[7]}}, mw[7:0]};
  end
  always @(posedge clock) if (mem_wen) begin
    mem[ma] <= mem_data[7:0];
    if (mem_acc_size != 2'd0) mem[ma + 12'd1] <= mem_data[15:8];
    if (mem_acc_size[1]) begin
      mem[ma + 12'd2] <= mem_data[23:16];
      mem[ma + 12'd3] <= mem_data[31:24];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        un;
    logic        write;
    logic [31:0] exp;
    logic        exp_split;
  } vec_t;
  typedef struct {
    logic [31:0] exp;
    logic        split;
    int          lat;
    int          c0;
  } sb_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        un;
    logic        wen;
  } acc_t;

  sb_t  sb[$];
  acc_t trace[$];
  int   compared = 0, mismatched = 0, cyc = 0, resp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (reset_n && !req_ready)
    trace.push_back('{mem_addr, mem_data, mem_acc_size, mem_un, mem_wen});

  always @(negedge clock) if (reset_n && resp_valid) begin
    sb_t e;
    resp_cnt++;
    if (sb.size() == 0) chk("unexpected resp_valid", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("resp_rdata", resp_rdata, e.exp);
      chk("resp_split", {31'd0, resp_split}, {31'd0, e.split});
      chk("resp latency", cyc - e.c0, e.lat);
    end
  end

  task automatic send(input vec_t v, input bit hold, output bit in_resp);
    int t = 0;
    @(negedge clock);
    req_addr = v.addr; req_wdata = v.wdata; req_size = v.size;
    req_unsigned = v.un; req_write = v.write; req_valid = 1'b1;
    while (!req_ready && t < 20) begin @(negedge clock); t++; end
    in_resp = resp_valid;
    if (!req_ready) begin
      chk("accept timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp, v.exp_split, v.exp_split ? (v.size == 2'd1 ? 3 : 5) : 2, cyc});
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 30) begin @(negedge clock); t++; end
    if (sb.size() != 0) begin
      chk("response timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic apply(input vec_t v);
    bit r;
    int n;
    trace.delete();
    send(v, 1'b0, r);
    drain();
    n = v.exp_split ? (v.size == 2'd1 ? 2 : 4) : 1;
    chk("access count", trace.size(), n);
    for (int j = 0; j < n && j < trace.size(); j++) begin
      chk("mem_addr", trace[j].addr, v.exp_split ? v.addr + 32'(j) : v.addr);
      chk("mem_data", trace[j].data, v.exp_split ? 32'(v.wdata >> (8 * j)) & 32'hFF : v.wdata);
      chk("mem_acc_size", {30'd0, trace[j].size}, v.exp_split ? 32'd0 : {30'd0, v.size});
      chk("mem_un", {31'd0, trace[j].un}, {31'd0, v.exp_split | v.un});
      chk("mem_wen", {31'd0, trace[j].wen}, {31'd0, v.write});
    end
  endtask

  vec_t tbl[15];
  vec_t b1, b2;
  bit   r1, r2;
  int   rc;

  initial begin
    tbl[0]  = '{32'h0000_0100, 32'h8899_AABB, 2'd2, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    tbl[1]  = '{32'h0000_0100, 32'h0,         2'd2, 1'b0, 1'b0, 32'h8899_AABB, 1'b0};
    tbl[2]  = '{32'h0000_0101, 32'h0000_0034, 2'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    tbl[3]  = '{32'h0000_0102, 32'h0000_00F2, 2'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    tbl[4]  = '{32'h0000_0101, 32'h0,         2'd1, 1'b0, 1'b0, 32'hFFFF_F234, 1'b1};
    tbl[5]  = '{32'h0000_0101, 32'h0,         2'd1, 1'b1, 1'b0, 32'h0000_F234, 1'b1};
    tbl[6]  = '{32'h0000_0203, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    tbl[7]  = '{32'h0000_0204, 32'h0,         2'd2, 1'b0, 1'b0, 32'h00DE_ADBE, 1'b0};
    tbl[8]  = '{32'h0000_0203, 32'h0,         2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    tbl[9]  = '{32'h0000_0206, 32'h0,         2'd0, 1'b0, 1'b0, 32'hFFFF_FFDE, 1'b0};
    tbl[10] = '{32'h0000_0100, 32'h0,         2'd1, 1'b1, 1'b0, 32'h0000_34BB, 1'b0};
    tbl[11] = '{32'h0000_0102, 32'h0,         2'd1, 1'b0, 1'b0, 32'hFFFF_88F2, 1'b0};
    tbl[12] = '{32'h0000_0201, 32'h0,         2'd3, 1'b0, 1'b0, 32'hBEEF_0000, 1'b1};
    tbl[13] = '{32'hFFFF_FFFF, 32'h0000_1234, 2'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    tbl[14] = '{32'hFFFF_FFFF, 32'h0,         2'd1, 1'b1, 1'b0, 32'h0000_1234, 1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; req_write = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_split", {31'd0, resp_split}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_data", mem_data, 32'd0);
    chk("reset mem_ctl", {28'd0, mem_acc_size, mem_un, mem_wen}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle req_ready", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i]) apply(tbl[i]);

    // Back-to-back: second request held valid through ACCESS and taken in RESP.
    b1 = '{32'h0000_0300, 32'h0000_005A, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0};
    b2 = '{32'h0000_0300, 32'h0,         2'd0, 1'b1, 1'b0, 32'h0000_005A, 1'b0};
    send(b1, 1'b1, r1);
    send(b2, 1'b0, r2);
    chk("b2b accepted in RESP", {31'd0, r2}, 32'd1);
    drain();

    // Reset pulse during byte 2 of a split store.
    b1 = '{32'h0000_0401, 32'h1122_3344, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1};
    send(b1, 1'b0, r1);
    repeat (3) @(negedge clock);
    chk("k2 mem_addr", mem_addr, 32'h0000_0403);
    chk("k2 mem_wen", {31'd0, mem_wen}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("abort req_ready", {31'd0, req_ready}, 32'd0);
    sb.delete();
    rc = resp_cnt;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clock);
    chk("no resp after abort", resp_cnt, rc);
    b1 = '{32'h0000_0400, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0033_4400, 1'b0};
    apply(b1);
    b1 = '{32'h0000_0404, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    apply(b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
